// File: rtl/mem_lsu.sv
// Load/store unit: one byte/half/word access at a time to a byte-enabled, negedge-sampled word memory.
// Optional build macro MEM_LSU_ALIGN_CHECK_EN rejects misaligned half/word and reserved-size requests.
module mem_lsu #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    input  logic [MEM_ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_en,
    output logic [3:0]                mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_din,
    input  logic [DATA_WIDTH-1:0]     mem_dout
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;

    logic [1:0]            state_r;
    logic [1:0]            off_r;
    logic [1:0]            size_r;
    logic                  unsigned_r;
    logic                  we_r;
    logic                  accept_s;
    logic                  err_s;
    logic [3:0]            lane_we_s;
    logic [DATA_WIDTH-1:0] lane_din_s;
    logic [DATA_WIDTH-1:0] load_data_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;

    assign req_ready = (state_r == ST_IDLE);
    assign accept_s  = req_valid && req_ready;

    // Request rejection decode (never rejects without the alignment check)
    always_comb begin
        err_s = 1'b0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        case (req_size)
            SZ_BYTE: err_s = 1'b0;
            SZ_HALF: err_s = req_addr[0];
            2'd2:    err_s = (req_addr[1:0] != 2'b00);
            default: err_s = 1'b1;
        endcase
`else
        err_s = 1'b0;
`endif
    end

    // Byte-lane strobes and replicated write data; half/word force-align on the low address bits
    always_comb begin
        lane_we_s  = 4'b0000;
        lane_din_s = req_wdata;
        case (req_size)
            SZ_BYTE: begin
                lane_we_s  = 4'b0001 << req_addr[1:0];
                lane_din_s = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_we_s  = 4'b0011 << {req_addr[1], 1'b0};
                lane_din_s = {2{req_wdata[15:0]}};
            end
            default: begin
                lane_we_s  = 4'b1111;
                lane_din_s = req_wdata;
            end
        endcase
        if (!req_we) begin
            lane_we_s = 4'b0000;
        end else begin
            lane_we_s = lane_we_s;
        end
    end

    // Lane extraction and sign/zero extension of the registered read word
    always_comb begin
        byte_s      = mem_dout[{off_r, 3'b000} +: 8];
        half_s      = off_r[1] ? mem_dout[31:16] : mem_dout[15:0];
        load_data_s = 32'h0000_0000;
        if (we_r) begin
            load_data_s = 32'h0000_0000;
        end else begin
            case (size_r)
                SZ_BYTE: load_data_s = unsigned_r ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
                SZ_HALF: load_data_s = unsigned_r ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
                default: load_data_s = mem_dout;
            endcase
        end
    end

    // Control FSM with registered memory-side and response-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            off_r      <= 2'b00;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            we_r       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= {MEM_ADDR_WIDTH{1'b0}};
            mem_din    <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        off_r      <= req_addr[1:0];
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        we_r       <= req_we;
                        if (err_s) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            state_r  <= ST_ACCESS;
                            mem_en   <= 1'b1;
                            mem_we   <= lane_we_s;
                            mem_addr <= req_addr[MEM_ADDR_WIDTH+1:2];
                            mem_din  <= lane_din_s;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 4'b0000;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= load_data_s;
                    state_r   <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: negedge memory model, byte-level reference model with scoreboard, directed and random requests.
module tb_mem_lsu;
    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din, mem_dout;

    mem_lsu #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    typedef struct { logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { logic [3:0] we; logic [9:0] addr; logic [31:0] din; logic [31:0] mask; } mem_t;

    rsp_t        exp_rsp[$];
    mem_t        exp_mem[$];
    rsp_t        rx;
    mem_t        mx;
    logic [31:0] mem_arr [0:1023];
    logic [7:0]  ref_bytes [0:4095];
    int          n_cmp = 0, n_fail = 0;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [3:0]  last_mem_we;
    logic [9:0]  last_mem_addr;
    logic        bp_en = 1'b0;
    logic [31:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word memory: writes enabled lanes and registers the old word at negedge
    always @(negedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem_arr[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
            mem_dout <= mem_arr[mem_addr];
        end
    end

    // Compare process: memory accesses and responses against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (exp_mem.size() == 0) check("unexpected_mem_en", 32'(mem_en), 32'd0);
                else begin
                    mx = exp_mem.pop_front();
                    check("mem_we", 32'(mem_we), 32'(mx.we));
                    check("mem_addr", 32'(mem_addr), 32'(mx.addr));
                    check("mem_din", mem_din & mx.mask, mx.din);
                    last_mem_we   = mem_we;
                    last_mem_addr = mem_addr;
                end
            end
            if (rsp_valid) begin
                check("resp_req_ready", 32'(req_ready), 32'd0);
                check("resp_mem_en", 32'(mem_en), 32'd0);
                if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                else begin
                    rx = exp_rsp[0];
                    check("rsp_rdata", rsp_rdata, rx.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(rx.err));
                    if (rsp_ready) begin
                        void'(exp_rsp.pop_front());
                        last_rdata = rsp_rdata;
                        last_err   = rsp_err;
                    end
                end
            end
        end
    end

    // Reference model: byte-addressed memory, expected strobes and responses
    task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [11:0] addr, input logic [31:0] wdata);
        int nb, base, lane;
        logic [63:0] val;
        logic err;
        rsp_t r;
        mem_t m;
        err = 1'b0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`endif
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = (int'(addr) / nb) * nb;
        r.err = err;
        r.rdata = 32'd0;
        if (!err) begin
            m.we = 4'd0; m.addr = 10'(base / 4); m.din = 32'd0; m.mask = 32'd0;
            val = 64'd0;
            for (int i = 0; i < nb; i++) begin
                lane = base % 4 + i;
                if (we) begin
                    ref_bytes[base + i] = wdata[8*i +: 8];
                    m.we[lane] = 1'b1;
                    m.din[8*lane +: 8] = wdata[8*i +: 8];
                    m.mask[8*lane +: 8] = 8'hFF;
                end else begin
                    val = val | (64'(ref_bytes[base + i]) << (8 * i));
                end
            end
            if (!we) begin
                if (!uns && val[8*nb - 1]) val = val | (~64'd0 << (8 * nb));
                r.rdata = val[31:0];
            end
            exp_mem.push_back(m);
        end
        exp_rsp.push_back(r);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check("timeout_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata);
        wait_idle();
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        model_req(we, size, uns, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Randomised response back-pressure
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_en) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;
        mem_dout = 32'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 12'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF); wait_idle();
        check("st_word_we", 32'(last_mem_we), 32'h0000000F);
        check("st_word_addr", 32'(last_mem_addr), 32'd4);
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'd0); wait_idle();
        check("ld_word", last_rdata, 32'hDEADBEEF);
        check("ld_word_err", 32'(last_err), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 12'h011, 32'd0); wait_idle();
`ifdef MEM_LSU_ALIGN_CHECK_EN
        check("ld_misaligned_err", 32'(last_err), 32'd1);
        check("ld_misaligned_data", last_rdata, 32'd0);
`else
        check("ld_misaligned_err", 32'(last_err), 32'd0);
        check("ld_misaligned_data", last_rdata, 32'hDEADBEEF);
`endif
        do_req(1'b1, 2'd0, 1'b0, 12'h013, 32'h000000A5); wait_idle();
        check("st_byte_we", 32'(last_mem_we), 32'h00000008);
        do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'd0); wait_idle();
        check("ld_byte_signed", last_rdata, 32'hFFFFFFA5);
        do_req(1'b0, 2'd0, 1'b1, 12'h013, 32'd0); wait_idle();
        check("ld_byte_unsigned", last_rdata, 32'h000000A5);
        do_req(1'b1, 2'd1, 1'b0, 12'h022, 32'h00008001); wait_idle();
        check("st_half_we", 32'(last_mem_we), 32'h0000000C);
        do_req(1'b0, 2'd1, 1'b0, 12'h022, 32'd0); wait_idle();
        check("ld_half_signed", last_rdata, 32'hFFFF8001);
        do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'd0); wait_idle();
        check("ld_word_after_half", last_rdata, 32'h80010000);

        // Back-pressure: response held stable for 5 cycles
        rsp_ready = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
        @(posedge clk); #1;
        held = rsp_rdata;
        check("bp_first_data", held, 32'hA5ADBEEF);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_mem_en", 32'(mem_en), 32'd0);
            check("bp_rdata_stable", rsp_rdata, held);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);

        // Reset while the access is in flight
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'd0);
        check("pre_rst_mem_en", 32'(mem_en), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_rsp.delete();
        exp_mem.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'd0); wait_idle();
        check("post_rst_load", last_rdata, 32'hA5ADBEEF);

        // Random traffic with random back-pressure
        bp_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 63)) : 12'($urandom_range(0, 4095)),
                   $urandom());
        end
        bp_en = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;
        check("final_rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        check("final_mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
